// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder around one fullAdder cell, start/done handshake.
// Defining SERIAL_ADDER_SUB_EN adds a sub port selecting a - b.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, fa_s, fa_c, sub_i;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  fullAdder u_fa (.a(a_sh_q[0]), .b(b_sh_q[0]), .cin(c_q), .s(fa_s), .cout(fa_c));
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == IDLE && start) begin
      state_d = SHIFT;
      a_sh_d  = a;
      b_sh_d  = sub_i ? ~b : b;
      c_d     = sub_i | cin;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      res_d  = WIDTH'({fa_s, res_q} >> 1);
      c_d    = fa_c;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        sum_d   = res_d;
        cout_d  = fa_c;
      end
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy     = state_q == SHIFT;
  assign done     = state_q == DONE;
  assign sum      = sum_q;
  assign carryOut = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed stimulus against a cycle-count model of the serial adder.
module tb_serial_adder;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         busy, done, carryOut;
  int           n_checks = 0, n_fail = 0;
  int           age = -1;
  logic [W:0]   pend = '0;
  logic [W-1:0] exp_sum = '0;
  logic         exp_co = 1'b0, armed = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .carryOut(carryOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: age counts edges since acceptance; result lands W edges later.
  always @(posedge clk) begin
    armed <= 1'b1;
    if (!rst_n) begin
      age     <= -1;
      exp_sum <= '0;
      exp_co  <= 1'b0;
    end else if (age < 0) begin
      if (start) begin
        age <= 0;
`ifdef SERIAL_ADDER_SUB_EN
        pend <= sub ? {1'b0, a} + {1'b0, ~b} + (W+1)'(1) : {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`else
        pend <= {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`endif
      end
    end else begin
      age <= (age == W) ? -1 : age + 1;
      if (age == W - 1) {exp_co, exp_sum} <= pend;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(busy), 32'(age >= 0 && age < W));
      chk("done", 32'(done), 32'(age == W));
      chk("sum", 32'(sum), 32'(exp_sum));
      chk("carryOut", 32'(carryOut), 32'(exp_co));
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, input logic [W-1:0] es, input logic ec, input string name);
    bit seen = 0;
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_cout"}, 32'(carryOut), 32'(ec));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(carryOut), 32'd0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    run_op(8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, "basic");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "carry1");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "allones");
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, "mixed");
    // A start pulsed mid-shift must be dropped; the model flags any extra done.
    fork
      run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, "ignored");
      begin
        repeat (3) @(negedge clk);
        chk("hold_sum", 32'(sum), 32'h00);
        a = 8'h80; b = 8'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    chk("no_second_busy", 32'(busy), 32'd0);
    a = 8'h3C; b = 8'h15; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    repeat (W + 3) @(negedge clk);
    run_op(8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, "after_rst");
`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub1");
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, "sub2");
    run_op(8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 1'b0, "sub_off");
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
